// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and the
// helper that sizes the bit counter.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Counter must hold 0..WIDTH; a 1-bit floor keeps WIDTH=1 legal.
   function automatic int cnt_width(input int width);
      int w;
      w = $clog2(width + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - z, bo is the borrow out.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic z,
   output logic d,
   output logic bo
);

   assign d  = x ^ y ^ z;
   assign bo = (~x & y) | (~(x ^ y) & z);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first: diff = a - b - bin over WIDTH
// cycles using one full-subtractor cell and a borrow flop.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start
//   ST_SHIFT | processing one bit per clock, busy high
//   ST_DONE  | one-cycle done pulse; start here reloads back-to-back
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             busy,
   output logic             done
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_nxt;

   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_r_sh;
   logic             r_brw;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;
   logic             r_busy;
   logic             r_done;

   logic             w_d;
   logic             w_bo;
   logic             w_load;
   logic             w_shift;
   logic             w_finish;
   logic             w_last;
   logic [WIDTH:0]   w_cat;
   logic [WIDTH-1:0] w_r_nxt;
   logic             w_unused_lsb;

   full_subtractor u_fs (
      .x  (r_a_sh[0]),
      .y  (r_b_sh[0]),
      .z  (r_brw),
      .d  (w_d),
      .bo (w_bo)
   );

   // New bit enters at the MSB; the bit falling off the LSB end is dropped.
   assign w_cat        = {w_d, r_r_sh};
   assign w_r_nxt      = w_cat[WIDTH:1];
   assign w_unused_lsb = w_cat[0];
   assign w_last       = (r_cnt == LAST_CNT);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            w_shift = 1'b1;
            if (w_last) begin
               w_finish    = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = ST_SHIFT;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_sh <= '0;
         r_b_sh <= '0;
         r_r_sh <= '0;
         r_brw  <= 1'b0;
         r_cnt  <= '0;
         r_diff <= '0;
         r_bout <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_finish;
         if (w_load) begin
            r_a_sh <= a;
            r_b_sh <= b;
            r_brw  <= bin;
            r_cnt  <= '0;
            r_busy <= 1'b1;
         end else if (w_shift) begin
            r_r_sh <= w_r_nxt;
            r_a_sh <= r_a_sh >> 1;
            r_b_sh <= r_b_sh >> 1;
            r_brw  <= w_bo;
            r_cnt  <= r_cnt + CW'(1);
            // Result registers move only on completion.
            if (w_finish) begin
               r_diff <= w_r_nxt;
               r_bout <= w_bo;
               r_busy <= 1'b0;
            end
         end
      end
   end

   assign diff = r_diff;
   assign bout = r_bout;
   assign busy = r_busy;
   assign done = r_done;

endmodule
